// File: rtl/window_stream_sequencer.sv
// window_stream_sequencer: frame-level gate between a valid/ready pixel stream and
// the 6x6 line-buffer window generator. Throttles input on line-buffer occupancy,
// clears the generator at frame start, tracks the window row/column and reports
// frame completion.
// Optional feature macro: WSEQ_STALL_CNT_EN (backpressure stall-cycle counter).
module window_stream_sequencer #(
   parameter int unsigned IMG_WIDTH  = 480,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned WIN        = 6,
   parameter int unsigned NUM_LB     = 7,
   parameter int unsigned CW         = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    src_pixel,
   input  logic          src_valid,
   output logic          src_ready,
   output logic [7:0]    lb_pixel,
   output logic          lb_pixel_valid,
   output logic          lb_reset,
   input  logic          win_valid,
   output logic [CW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          busy,
   output logic          frame_done,
   output logic          seq_err,
   output logic [15:0]   stall_cycles
);

   localparam int unsigned OW = $clog2(NUM_LB * IMG_WIDTH + 1);
   localparam int unsigned IW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

   localparam logic [OW-1:0] OCC_FULL = OW'(NUM_LB * IMG_WIDTH);
   localparam logic [OW-1:0] ROW_PIX  = OW'(IMG_WIDTH);
   localparam logic [IW-1:0] PIX_LAST = IW'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] ROW_LAST = CW'(IMG_HEIGHT - WIN);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    r_state,      w_state_nxt;
   logic [OW-1:0] r_occ,        w_occ_nxt;
   logic [IW-1:0] r_in_cnt,     w_in_cnt_nxt;
   logic [CW-1:0] r_win_row,    w_win_row_nxt;
   logic [CW-1:0] r_win_col,    w_win_col_nxt;
   logic          r_busy,       w_busy_nxt;
   logic          r_frame_done, w_frame_done_nxt;
   logic          r_seq_err,    w_seq_err_nxt;

   logic w_start_acc;
   logic w_src_ready;
   logic w_accept;
   logic w_counting;
   logic w_win_cnt;
   logic w_row_end;
   logic w_row_free;
   logic w_last_win;

   // Handshake and window-event decode, all from registered state
   assign w_start_acc = start && (r_state == S_IDLE);
   assign w_src_ready = (r_state == S_STREAM) && (r_occ < OCC_FULL);
   assign w_accept    = src_valid && w_src_ready;
   assign w_counting  = (r_state == S_STREAM) || (r_state == S_DRAIN);
   assign w_win_cnt   = win_valid && w_counting;
   assign w_row_end   = w_win_cnt && (r_win_col == COL_LAST);
   assign w_row_free  = w_row_end && (r_occ >= ROW_PIX);
   assign w_last_win  = w_row_end && (r_win_row == ROW_LAST);

   // Next-state and datapath update; an accepted start overrides everything
   always_comb begin
      w_state_nxt      = r_state;
      w_occ_nxt        = r_occ;
      w_in_cnt_nxt     = r_in_cnt;
      w_win_row_nxt    = r_win_row;
      w_win_col_nxt    = r_win_col;
      w_busy_nxt       = r_busy;
      w_frame_done_nxt = 1'b0;
      w_seq_err_nxt    = r_seq_err;

      // Stray window outside a frame, or a row completion the buffers cannot back
      if (win_valid && !w_counting) begin
         w_seq_err_nxt = 1'b1;
      end
      if (w_row_end && !w_row_free) begin
         w_seq_err_nxt = 1'b1;
      end

      // Accept and row release may coincide; fold both into one update
      case ({w_accept, w_row_free})
         2'b10:   w_occ_nxt = r_occ + OW'(1);
         2'b01:   w_occ_nxt = r_occ - ROW_PIX;
         2'b11:   w_occ_nxt = r_occ + OW'(1) - ROW_PIX;
         default: w_occ_nxt = r_occ;
      endcase

      if (w_accept) begin
         w_in_cnt_nxt = r_in_cnt + IW'(1);
      end

      if (w_win_cnt) begin
         if (r_win_col == COL_LAST) begin
            w_win_col_nxt = '0;
            if (r_win_row != ROW_LAST) begin
               w_win_row_nxt = r_win_row + CW'(1);
            end
         end else begin
            w_win_col_nxt = r_win_col + CW'(1);
         end
      end

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt   = S_STREAM;
               w_occ_nxt     = '0;
               w_in_cnt_nxt  = '0;
               w_win_row_nxt = '0;
               w_win_col_nxt = '0;
               w_busy_nxt    = 1'b1;
               w_seq_err_nxt = 1'b0;
            end
         end
         S_STREAM: begin
            if (w_last_win) begin
               w_state_nxt      = S_DONE;
               w_busy_nxt       = 1'b0;
               w_frame_done_nxt = 1'b1;
            end else if (w_accept && (r_in_cnt == PIX_LAST)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_last_win) begin
               w_state_nxt      = S_DONE;
               w_busy_nxt       = 1'b0;
               w_frame_done_nxt = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_occ        <= '0;
         r_in_cnt     <= '0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_seq_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_occ        <= w_occ_nxt;
         r_in_cnt     <= w_in_cnt_nxt;
         r_win_row    <= w_win_row_nxt;
         r_win_col    <= w_win_col_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_seq_err    <= w_seq_err_nxt;
      end
   end

`ifdef WSEQ_STALL_CNT_EN
   logic [15:0] r_stall_cycles;

   // Saturating count of backpressured cycles within a frame
   always_ff @(posedge clk) begin
      if (reset || w_start_acc) begin
         r_stall_cycles <= '0;
      end else if (src_valid && !w_src_ready && r_busy && (r_stall_cycles != 16'hFFFF)) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = 16'd0;
`endif

   assign src_ready      = w_src_ready;
   assign lb_pixel       = src_pixel;
   assign lb_pixel_valid = w_accept;
   assign lb_reset       = reset | w_start_acc;
   assign win_row        = r_win_row;
   assign win_col        = r_win_col;
   assign busy           = r_busy;
   assign frame_done     = r_frame_done;
   assign seq_err        = r_seq_err;

endmodule

// File: tb/tb_window_stream_sequencer.sv
// Bench for window_stream_sequencer on an 8x8 image with a behavioural window
// generator; pixel and frame-done scoreboards plus a table of control vectors.
module tb_window_stream_sequencer;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int WN   = 6;
   localparam int NLB  = 7;
   localparam int NWIN = (H - WN + 1) * W;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] src_pixel;
   logic       src_valid;
   logic       src_ready;
   logic [7:0] lb_pixel;
   logic       lb_pixel_valid;
   logic       lb_reset;
   logic       win_valid;
   logic [8:0] win_row;
   logic [8:0] win_col;
   logic       busy;
   logic       frame_done;
   logic       seq_err;
   logic [15:0] stall_cycles;

   window_stream_sequencer #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .WIN       (WN),
      .NUM_LB    (NLB),
      .CW        (9)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .src_pixel     (src_pixel),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .lb_pixel      (lb_pixel),
      .lb_pixel_valid(lb_pixel_valid),
      .lb_reset      (lb_reset),
      .win_valid     (win_valid),
      .win_row       (win_row),
      .win_col       (win_col),
      .busy          (busy),
      .frame_done    (frame_done),
      .seq_err       (seq_err),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

`ifdef WSEQ_STALL_CNT_EN
   localparam int EXP_STALL = 10;
`else
   localparam int EXP_STALL = 0;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int  px_cnt, win_cnt, occ_m, acc_cnt, wv_cnt, fd_cnt, gen_lim;
   bit  gen_en, drv_valid, m_stream, m_busy;
   logic [7:0] px_q[$];
   int  fd_q[$];

   typedef struct {
      logic rst;
      logic st;
      logic wv;
      logic exp_lbr;
      logic exp_rdy;
      logic exp_busy;
      logic exp_err;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Last pixel index (1-based count) needed before window k can be produced
   function automatic int need_px(input int k);
      return (k / W + WN - 1) * W + (k % W) + 1;
   endfunction

   task automatic model_clear();
      px_cnt   = 0;
      win_cnt  = 0;
      occ_m    = 0;
      m_stream = 1'b0;
      m_busy   = 1'b0;
      px_q.delete();
      fd_q.delete();
   endtask

   // One clock cycle: drive at negedge, check, update model at posedge
   task automatic tick();
      bit exp_rdy, acc, wv, exp_fd;
      logic [7:0] pix;
      exp_rdy   = m_stream && (occ_m < NLB * W);
      wv        = gen_en && (win_cnt < gen_lim) && (px_cnt >= need_px(win_cnt));
      pix       = 8'($urandom);
      win_valid = wv;
      src_valid = drv_valid;
      src_pixel = pix;
      #1;
      chk("src_ready", int'(src_ready), int'(exp_rdy));
      acc = drv_valid && exp_rdy;
      chk("lb_pixel_valid", int'(lb_pixel_valid), int'(acc));
      if (acc) px_q.push_back(pix);
      if (lb_pixel_valid) begin
         chk("lb_pixel_queued", px_q.size(), 1);
         if (px_q.size() > 0) chk("lb_pixel", int'(lb_pixel), int'(px_q.pop_front()));
      end
      px_q.delete();
      if (wv) begin
         chk("win_row", int'(win_row), win_cnt / W);
         chk("win_col", int'(win_col), win_cnt % W);
      end
      chk("busy", int'(busy), int'(m_busy));
      chk("seq_err", int'(seq_err), 0);
      @(posedge clk);
      if (acc) begin
         px_cnt++;
         acc_cnt++;
         occ_m++;
         if (px_cnt == W * H) m_stream = 1'b0;
      end
      if (wv) begin
         if (win_cnt % W == W - 1) occ_m -= W;
         win_cnt++;
         wv_cnt++;
         if (win_cnt == NWIN) begin
            fd_q.push_back(1);
            m_busy = 1'b0;
         end
      end
      @(negedge clk);
      exp_fd = (fd_q.size() > 0);
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (exp_fd) void'(fd_q.pop_front());
      if (frame_done) fd_cnt++;
   endtask

   task automatic do_start();
      start     = 1'b1;
      src_valid = 1'b0;
      win_valid = 1'b0;
      #1;
      chk("lb_reset_on_start", int'(lb_reset), 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      #1;
      model_clear();
      m_stream = 1'b1;
      m_busy   = 1'b1;
      acc_cnt  = 0;
      wv_cnt   = 0;
      fd_cnt   = 0;
      chk("lb_reset_pulse_end", int'(lb_reset), 0);
      chk("busy_after_start", int'(busy), 1);
      chk("seq_err_after_start", int'(seq_err), 0);
      chk("stall_after_start", int'(stall_cycles), 0);
      chk("win_row_after_start", int'(win_row), 0);
      chk("win_col_after_start", int'(win_col), 0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      start     = 1'b0;
      src_valid = 1'b0;
      win_valid = 1'b0;
      #1;
      chk("lb_reset_in_reset", int'(lb_reset), 1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      #1;
      chk("rst_src_ready", int'(src_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_seq_err", int'(seq_err), 0);
      chk("rst_stall", int'(stall_cycles), 0);
      chk("rst_win_row", int'(win_row), 0);
      chk("rst_win_col", int'(win_col), 0);
   endtask

   // Release the generator, run to frame_done, then let DONE return to IDLE
   task automatic finish_frame();
      gen_en  = 1'b1;
      gen_lim = NWIN;
      for (int i = 0; i < 400 && fd_cnt == 0; i++) tick();
      chk("frame_done_seen", fd_cnt, 1);
      chk("busy_in_done", int'(busy), 0);
      drv_valid = 1'b0;
      tick();
      tick();
      chk("frame_done_once", fd_cnt, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      reset     = 1'b1;
      start     = 1'b0;
      src_valid = 1'b0;
      src_pixel = 8'd0;
      win_valid = 1'b0;
      gen_en    = 1'b0;
      drv_valid = 1'b0;
      gen_lim   = 0;
      acc_cnt   = 0;
      wv_cnt    = 0;
      fd_cnt    = 0;
      model_clear();
      repeat (3) @(negedge clk);

      // Reset state
      chk("init_src_ready", int'(src_ready), 0);
      chk("init_busy", int'(busy), 0);
      chk("init_frame_done", int'(frame_done), 0);
      chk("init_seq_err", int'(seq_err), 0);
      chk("init_stall", int'(stall_cycles), 0);
      chk("init_lb_reset", int'(lb_reset), 1);
      chk("init_win_row", int'(win_row), 0);

      // Control vectors: start/ignored start/seq_err set and clear/reset
      for (int i = 0; i < 10; i++) begin
         reset     = tbl[i].rst;
         start     = tbl[i].st;
         win_valid = tbl[i].wv;
         src_valid = 1'b0;
         #1;
         chk($sformatf("vec%0d_lb_reset", i), int'(lb_reset), int'(tbl[i].exp_lbr));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_src_ready", i), int'(src_ready), int'(tbl[i].exp_rdy));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
         chk($sformatf("vec%0d_seq_err", i), int'(seq_err), int'(tbl[i].exp_err));
         chk($sformatf("vec%0d_frame_done", i), int'(frame_done), 0);
      end
      reset     = 1'b0;
      start     = 1'b0;
      win_valid = 1'b0;
      model_clear();

      // Full frame with a continuously valid source
      do_start();
      drv_valid = 1'b1;
      finish_frame();
      chk("t1_pixels", acc_cnt, W * H);
      chk("t1_windows", wv_cnt, NWIN);
      chk("t1_final_row", int'(win_row), H - WN);

      // Backpressure: buffers fill at NUM_LB rows, one row of windows frees them
      do_start();
      gen_en    = 1'b0;
      drv_valid = 1'b1;
      for (int i = 0; i < 200 && acc_cnt < NLB * W; i++) tick();
      chk("t2_fill", acc_cnt, NLB * W);
      repeat (10) tick();
      chk("t2_no_more_accepts", acc_cnt, NLB * W);
      chk("t2_ready_low", int'(src_ready), 0);
      chk("t2_stall_cycles", int'(stall_cycles), EXP_STALL);
      drv_valid = 1'b0;
      gen_en    = 1'b1;
      gen_lim   = W;
      for (int i = 0; i < 50 && win_cnt < W; i++) tick();
      chk("t2_row_windows", win_cnt, W);
      chk("t2_ready_back", int'(src_ready), 1);
      drv_valid = 1'b1;
      finish_frame();
      chk("t2_pixels", acc_cnt, W * H);

      // Accept and row completion in the same cycle
      do_start();
      gen_en    = 1'b0;
      drv_valid = 1'b1;
      for (int i = 0; i < 200 && acc_cnt < 55; i++) tick();
      drv_valid = 1'b0;
      gen_en    = 1'b1;
      gen_lim   = W - 1;
      for (int i = 0; i < 50 && win_cnt < W - 1; i++) tick();
      chk("t3_occ_before", int'(dut.r_occ), 55);
      drv_valid = 1'b1;
      gen_lim   = W;
      tick();
      chk("t3_both_accept", acc_cnt, 56);
      chk("t3_both_window", win_cnt, W);
      chk("t3_occ_atomic", int'(dut.r_occ), 48);
      gen_en = 1'b0;
      for (int i = 0; i < 40 && acc_cnt < W * H; i++) tick();
      chk("t3_pixels", acc_cnt, W * H);
      finish_frame();

      // Reset mid-frame, then a clean frame
      do_start();
      drv_valid = 1'b1;
      gen_en    = 1'b1;
      gen_lim   = NWIN;
      for (int i = 0; i < 100 && acc_cnt < 30; i++) tick();
      chk("t5_pixels_before_reset", acc_cnt, 30);
      do_reset();
      drv_valid = 1'b0;
      repeat (4) tick();
      chk("t5_no_frame_done", fd_cnt, 0);
      do_start();
      drv_valid = 1'b1;
      finish_frame();
      chk("t5_pixels", acc_cnt, W * H);
      chk("t5_windows", wv_cnt, NWIN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
